// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: 640x480@60 (current board) and 800x600@72 (later boards).
package vga_timing_pkg;

  localparam int unsigned AddrW = 11;

  // 640x480@60, 25 MHz pixel clock
  localparam int unsigned H640Sync   = 96;
  localparam int unsigned H640Back   = 48;
  localparam int unsigned H640Active = 640;
  localparam int unsigned H640Front  = 16;
  localparam int unsigned V480Sync   = 2;
  localparam int unsigned V480Back   = 33;
  localparam int unsigned V480Active = 480;
  localparam int unsigned V480Front  = 10;

  localparam int unsigned H640Total = H640Sync + H640Back + H640Active + H640Front;
  localparam int unsigned V480Total = V480Sync + V480Back + V480Active + V480Front;
  localparam int unsigned H640Start = H640Sync + H640Back;
  localparam int unsigned V480Start = V480Sync + V480Back;

  // 800x600@72, 50 MHz pixel clock
  localparam int unsigned H800Sync   = 120;
  localparam int unsigned H800Back   = 64;
  localparam int unsigned H800Active = 800;
  localparam int unsigned H800Front  = 56;
  localparam int unsigned V600Sync   = 6;
  localparam int unsigned V600Back   = 23;
  localparam int unsigned V600Active = 600;
  localparam int unsigned V600Front  = 37;

  localparam int unsigned H800Total = H800Sync + H800Back + H800Active + H800Front;
  localparam int unsigned V600Total = V600Sync + V600Back + V600Active + V600Front;
  localparam int unsigned H800Start = H800Sync + H800Back;
  localparam int unsigned V600Start = V600Sync + V600Back;

endpackage

// File: rtl/vga_sync_delay.sv
// Parameterised single-bit shift register; Depth 0 is a plain wire.
module vga_sync_delay #(
  parameter int unsigned Depth    = 1,
  parameter logic        ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  if (Depth == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_sr
    logic [Depth-1:0] sr_q;

    // Shift towards the MSB; synchronous reset loads the inactive level.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sr_q <= {Depth{ResetVal}};
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < Depth; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign q_o = sr_q[Depth-1];
  end

endmodule

// File: rtl/vga_sync_module.sv
// VGA timing generator: free-running counters, visible-window decode, sync delay line.
module vga_sync_module
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = H640Sync,
  parameter int unsigned H_BACK   = H640Back,
  parameter int unsigned H_ACTIVE = H640Active,
  parameter int unsigned H_FRONT  = H640Front,
  parameter int unsigned V_SYNC   = V480Sync,
  parameter int unsigned V_BACK   = V480Back,
  parameter int unsigned V_ACTIVE = V480Active,
  parameter int unsigned V_FRONT  = V480Front,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned SYNC_DLY = 1
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             HSYNC_Sig,
  output logic             VSYNC_Sig,
  output logic             Ready_Sig,
  output logic [AddrW-1:0] Column_Addr_Sig,
  output logic [AddrW-1:0] Row_Addr_Sig,
  output logic             Frame_Start_Sig
);

  localparam logic [AddrW-1:0] HLast  = AddrW'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam logic [AddrW-1:0] VLast  = AddrW'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam logic [AddrW-1:0] HStart = AddrW'(H_SYNC + H_BACK);
  localparam logic [AddrW-1:0] VStart = AddrW'(V_SYNC + V_BACK);
  localparam logic [AddrW-1:0] HEnd   = AddrW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [AddrW-1:0] VEnd   = AddrW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [AddrW-1:0] HSyncW = AddrW'(H_SYNC);
  localparam logic [AddrW-1:0] VSyncW = AddrW'(V_SYNC);

  logic [AddrW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic             ready_q, fs_q, hs_q, vs_q;
  logic [AddrW-1:0] col_q, row_q;
  logic             win, hs_raw, vs_raw;

  // Counter next state: vertical steps on the last pixel of a line, both wrap together.
  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 11'd1;
    end
  end

  // Window and sync-phase decode from the current counter state.
  always_comb begin
    win    = (h_cnt_q >= HStart) && (h_cnt_q < HEnd) && (v_cnt_q >= VStart) && (v_cnt_q < VEnd);
    hs_raw = h_cnt_q < HSyncW;
    vs_raw = v_cnt_q < VSyncW;
  end

  // Counters and one-cycle-latency registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      ready_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      fs_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      ready_q <= win;
      // Subtraction only used inside the window so it cannot underflow.
      col_q   <= win ? h_cnt_q - HStart : '0;
      row_q   <= win ? v_cnt_q - VStart : '0;
      fs_q    <= (h_cnt_q == HStart) && (v_cnt_q == VStart);
      hs_q    <= hs_raw ? SYNC_POL : ~SYNC_POL;
      vs_q    <= vs_raw ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Extra delay so the syncs line up with the colour-stage register downstream.
  vga_sync_delay #(
    .Depth   (SYNC_DLY),
    .ResetVal(~SYNC_POL)
  ) u_hs_dly (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (hs_q),
    .q_o  (HSYNC_Sig)
  );

  vga_sync_delay #(
    .Depth   (SYNC_DLY),
    .ResetVal(~SYNC_POL)
  ) u_vs_dly (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (vs_q),
    .q_o  (VSYNC_Sig)
  );

  assign Ready_Sig       = ready_q;
  assign Column_Addr_Sig = col_q;
  assign Row_Addr_Sig    = row_q;
  assign Frame_Start_Sig = fs_q;

endmodule

// File: tb/tb_vga_sync_module.sv
// Bench: two small-timing instances (SYNC_DLY 2 and 0) with random resets, plus the
// default 640x480 instance run past its first visible row; all compared to a cycle model.
module tb_vga_sync_module;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        rdy;
    logic        fs;
    logic [10:0] col;
    logic [10:0] row;
  } exp_t;

  logic clk = 1'b0;
  logic rst_s, rst_d;
  logic run = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_s = -1000;
  int   n_d = -1000;

  always #5 clk = ~clk;

  // Small instance A: SYNC_DLY=2, active-low
  logic        a_hs, a_vs, a_rdy, a_fs;
  logic [10:0] a_col, a_row;
  vga_sync_module #(
    .H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(5), .V_FRONT(2),
    .SYNC_POL(1'b0), .SYNC_DLY(2)
  ) u_a (
    .CLK(clk), .RST(rst_s), .HSYNC_Sig(a_hs), .VSYNC_Sig(a_vs), .Ready_Sig(a_rdy),
    .Column_Addr_Sig(a_col), .Row_Addr_Sig(a_row), .Frame_Start_Sig(a_fs)
  );

  // Small instance B: SYNC_DLY=0, active-high pulse
  logic        b_hs, b_vs, b_rdy, b_fs;
  logic [10:0] b_col, b_row;
  vga_sync_module #(
    .H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(5), .V_FRONT(2),
    .SYNC_POL(1'b1), .SYNC_DLY(0)
  ) u_b (
    .CLK(clk), .RST(rst_s), .HSYNC_Sig(b_hs), .VSYNC_Sig(b_vs), .Ready_Sig(b_rdy),
    .Column_Addr_Sig(b_col), .Row_Addr_Sig(b_row), .Frame_Start_Sig(b_fs)
  );

  // Default 640x480@60 instance
  logic        d_hs, d_vs, d_rdy, d_fs;
  logic [10:0] d_col, d_row;
  vga_sync_module u_d (
    .CLK(clk), .RST(rst_d), .HSYNC_Sig(d_hs), .VSYNC_Sig(d_vs), .Ready_Sig(d_rdy),
    .Column_Addr_Sig(d_col), .Row_Addr_Sig(d_row), .Frame_Start_Sig(d_fs)
  );

  // Expected outputs n edges after the last reset edge (n=0 is the reset edge itself).
  // Outputs reflect the counter state of pixel n-1; syncs that of pixel n-1-dly.
  function automatic exp_t model(input int n, input int hsy, input int hb, input int ha,
                                 input int hf, input int vsy, input int vb, input int va,
                                 input int vf, input bit pol, input int dly);
    exp_t e;
    int   ht, vt, k, h, v;
    ht    = hsy + hb + ha + hf;
    vt    = vsy + vb + va + vf;
    e     = '0;
    e.hs  = !pol;
    e.vs  = !pol;
    if (n >= 1) begin
      k = n - 1;
      h = k % ht;
      v = (k / ht) % vt;
      if (h >= hsy + hb && h < hsy + hb + ha && v >= vsy + vb && v < vsy + vb + va) begin
        e.rdy = 1'b1;
        e.col = 11'(h - hsy - hb);
        e.row = 11'(v - vsy - vb);
        e.fs  = (h == hsy + hb) && (v == vsy + vb);
      end
    end
    if (n >= 1 + dly) begin
      k    = n - 1 - dly;
      h    = k % ht;
      v    = (k / ht) % vt;
      e.hs = (h < hsy) ? pol : !pol;
      e.vs = (v < vsy) ? pol : !pol;
    end
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_dut(input string name, input exp_t e, input logic hs, input logic vs,
                           input logic rdy, input logic fs, input logic [10:0] col,
                           input logic [10:0] row);
    check_eq({name, ".hsync"}, 32'(hs), 32'(e.hs));
    check_eq({name, ".vsync"}, 32'(vs), 32'(e.vs));
    check_eq({name, ".ready"}, 32'(rdy), 32'(e.rdy));
    check_eq({name, ".frame_start"}, 32'(fs), 32'(e.fs));
    check_eq({name, ".column"}, 32'(col), 32'(e.col));
    check_eq({name, ".row"}, 32'(row), 32'(e.row));
  endtask

  // Reference edge counters since the most recent reset edge.
  always @(posedge clk) begin
    n_s <= rst_s ? 0 : n_s + 1;
    n_d <= rst_d ? 0 : n_d + 1;
  end

  // Compare away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      if (n_s >= 0) begin
        check_dut("a", model(n_s, 4, 3, 10, 2, 2, 3, 5, 2, 1'b0, 2),
                  a_hs, a_vs, a_rdy, a_fs, a_col, a_row);
        check_dut("b", model(n_s, 4, 3, 10, 2, 2, 3, 5, 2, 1'b1, 0),
                  b_hs, b_vs, b_rdy, b_fs, b_col, b_row);
      end
      if (n_d >= 0) begin
        check_dut("d", model(n_d, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1),
                  d_hs, d_vs, d_rdy, d_fs, d_col, d_row);
      end
    end
  end

  initial begin
    exp_t e;
    bit   mid_done;
    int   rst_len;
    mid_done = 1'b0;
    rst_s    = 1'b1;
    rst_d    = 1'b1;
    run      = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    rst_d = 1'b0;
    for (int cyc = 0; cyc < 29500; cyc++) begin
      @(negedge clk);
      rst_s = 1'b0;
      // Deterministic reset mid visible line of the small instances (row 2, column 5).
      e = model(n_s, 4, 3, 10, 2, 2, 3, 5, 2, 1'b0, 2);
      if (!mid_done && cyc > 1500 && e.rdy && e.row == 11'd2 && e.col == 11'd5) begin
        mid_done = 1'b1;
        rst_s    = 1'b1;
      end else if (cyc > 3000 && $urandom_range(0, 599) == 0) begin
        rst_len = $urandom_range(1, 3);
        rst_s   = 1'b1;
        repeat (rst_len - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    run = 1'b0;
    check_eq("mid_line_reset_seen", 32'(mid_done), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
